// File: rtl/ps2_rx_fifo_pkg.sv
// Shared PS/2 constants and the frame validity check used by the receiver.
package ps2_rx_fifo_pkg;

  localparam int         PS2_FRAME_BITS = 11;
  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXTEND     = 8'hE0;
  localparam logic [3:0] PS2_LAST_BIT   = 4'(PS2_FRAME_BITS - 1);

  // bits[0]=start, bits[8:1]=data, bits[9]=odd parity; stop arrives live with bit 10
  function automatic logic frameOk(input logic [9:0] bits, input logic stopBit);
    return (bits[0] == 1'b0) && stopBit && (^bits[9:1]);
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Multi-flop synchroniser for one asynchronous PS/2 line, with a falling-edge pulse.
module ps2_sync_edge #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic clrn,
  input  logic i_async,
  output logic o_level,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_last;

  // Idle PS/2 lines are high, so the chain resets to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_sync <= '1;
      r_last <= 1'b1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_last <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_fall  = r_last & ~r_sync[STAGES-1];

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: deserialises and checks 11-bit frames, queues good bytes.
module ps2_rx_fifo
  import ps2_rx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2     = 3,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  logic w_clkFall;
  logic w_dataLvl;

  logic [3:0]            r_bitCnt;
  logic [9:0]            r_frame;
  logic [TW-1:0]         r_timeout;
  logic                  r_frameErr;
  logic                  r_overflow;
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wrPtr;
  logic [DEPTH_LOG2-1:0] r_rdPtr;
  logic [DEPTH_LOG2:0]   r_count;

  logic w_lastBit;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_write;
  logic w_timeoutHit;

  ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_syncClk (
    .clk     (clk),
    .clrn    (clrn),
    .i_async (ps2_clk),
    .o_level (),
    .o_fall  (w_clkFall)
  );

  ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_syncData (
    .clk     (clk),
    .clrn    (clrn),
    .i_async (ps2_data),
    .o_level (w_dataLvl),
    .o_fall  ()
  );

  assign w_lastBit    = w_clkFall && (r_bitCnt == PS2_LAST_BIT);
  assign w_push       = w_lastBit && frameOk(r_frame, w_dataLvl);
  assign w_pop        = !nextdata_n && (r_count != '0);
  assign w_full       = (r_count == (DEPTH_LOG2+1)'(DEPTH));
  assign w_write      = w_push && (!w_full || w_pop);
  assign w_timeoutHit = (r_bitCnt != 4'd0) && !w_clkFall &&
                        (r_timeout == TW'(TIMEOUT_CYCLES - 1));

  // The stop bit is never stored; it is checked live on the edge that carries it.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_bitCnt  <= 4'd0;
      r_frame   <= '0;
      r_timeout <= '0;
    end else if (w_clkFall) begin
      r_timeout <= '0;
      if (w_lastBit) begin
        r_bitCnt <= 4'd0;
      end else begin
        r_bitCnt          <= r_bitCnt + 4'd1;
        r_frame[r_bitCnt] <= w_dataLvl;
      end
    end else if (w_timeoutHit) begin
      r_bitCnt  <= 4'd0;
      r_timeout <= '0;
    end else if (r_bitCnt != 4'd0) begin
      r_timeout <= r_timeout + TW'(1);
    end else begin
      r_timeout <= '0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_frameErr <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_frameErr <= w_lastBit && !w_push;
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wrPtr] <= r_frame[8:1];
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_write) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Stale storage is masked so the head byte reads 0 whenever the queue is empty.
  assign ready     = (r_count != '0);
  assign data      = ready ? r_mem[r_rdPtr] : 8'h00;
  assign overflow  = r_overflow;
  assign frame_err = r_frameErr;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed self-checking bench for ps2_rx_fifo using a shortened PS/2 bit period.
module tb_ps2_rx_fifo;

  logic       clk = 1'b0;
  logic       clrn;
  logic       ps2_clk;
  logic       ps2_data;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int errors = 0;
  int checks = 0;
  int errRises = 0;
  int errCycles = 0;
  logic errPrev = 1'b0;

  ps2_rx_fifo #(
    .DEPTH_LOG2     (3),
    .SYNC_STAGES    (3),
    .TIMEOUT_CYCLES (200)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #10 clk = ~clk;

  // frame_err is tracked on the falling clock edge: number of pulses and of high cycles
  always @(negedge clk) begin
    if (frame_err) errCycles++;
    if (frame_err && !errPrev) errRises++;
    errPrev = frame_err;
  end

  function automatic logic [10:0] makeFrame(input logic [7:0] b, input logic flipPar);
    return {1'b1, (~^b) ^ flipPar, b, 1'b0};
  endfunction

  // PS/2 bit: data set, 10 cycles later clock falls, low 20 cycles, high 10 cycles
  task automatic sendBits(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk); ps2_data = f[i];
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (20) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
    end
    ps2_data = 1'b1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    sendBits(makeFrame(b, 1'b0), 0, 10);
    repeat (5) @(negedge clk);
  endtask

  task automatic popOnce();
    @(negedge clk); nextdata_n = 1'b0;
    @(negedge clk); nextdata_n = 1'b1;
  endtask

  task automatic test_reset();
    clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({ready, overflow, frame_err, data} !== 11'h000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got rdy=%b ovf=%b err=%b data=%h expected all 0",
               ready, overflow, frame_err, data);
    end
    clrn = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single();
    int e0 = errRises;
    logic [10:0] f = makeFrame(8'h1C, 1'b0);
    sendBits(f, 0, 9);
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("[TB] FAIL single_ready_before_stop: got %b expected 0", ready);
    end
    sendBits(f, 10, 10);
    checks++;
    if (ready !== 1'b1 || data !== 8'h1C) begin
      errors++; $display("[TB] FAIL single_data: got rdy=%b data=%h expected 1/1c", ready, data);
    end
    checks++;
    if (errRises !== e0) begin
      errors++; $display("[TB] FAIL single_no_err: got %0d pulses expected 0", errRises - e0);
    end
    popOnce();
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("[TB] FAIL single_empty_after_pop: got %b expected 0", ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3] = '{8'h1C, 8'hF0, 8'h1C};
    for (int i = 0; i < 3; i++) sendByte(exp[i]);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ready !== 1'b1 || data !== exp[i]) begin
        errors++;
        $display("[TB] FAIL b2b_pop%0d: got rdy=%b data=%h expected 1/%h", i, ready, data, exp[i]);
      end
      popOnce();
    end
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_empty: got %b expected 0", ready);
    end
  endtask

  task automatic test_parity_error();
    int e0 = errRises;
    int c0 = errCycles;
    sendBits(makeFrame(8'h1C, 1'b1), 0, 10);
    repeat (5) @(negedge clk);
    checks++;
    if (errRises - e0 !== 1) begin
      errors++; $display("[TB] FAIL perr_pulses: got %0d expected 1", errRises - e0);
    end
    checks++;
    if (errCycles - c0 !== 1) begin
      errors++; $display("[TB] FAIL perr_width: got %0d cycles expected 1", errCycles - c0);
    end
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("[TB] FAIL perr_no_push: got ready=%b expected 0", ready);
    end
    sendByte(8'h1B);
    checks++;
    if (ready !== 1'b1 || data !== 8'h1B || errRises - e0 !== 1) begin
      errors++;
      $display("[TB] FAIL perr_recover: got rdy=%b data=%h pulses=%0d expected 1/1b/1",
               ready, data, errRises - e0);
    end
    popOnce();
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 8; i++) sendByte(8'(i));
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("[TB] FAIL ovf_at_full: got %b expected 0", overflow);
    end
    sendByte(8'h09);
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("[TB] FAIL ovf_set: got %b expected 1", overflow);
    end
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (ready !== 1'b1 || data !== 8'(i)) begin
        errors++;
        $display("[TB] FAIL ovf_pop%0d: got rdy=%b data=%h expected 1/%h", i, ready, data, 8'(i));
      end
      popOnce();
    end
    checks++;
    if (ready !== 1'b0 || overflow !== 1'b1) begin
      errors++; $display("[TB] FAIL ovf_drained: got rdy=%b ovf=%b expected 0/1", ready, overflow);
    end
  endtask

  task automatic test_timeout();
    int e0 = errRises;
    sendBits(makeFrame(8'h55, 1'b0), 0, 4);
    repeat (300) @(negedge clk);
    sendByte(8'h23);
    checks++;
    if (ready !== 1'b1 || data !== 8'h23) begin
      errors++; $display("[TB] FAIL timeout_data: got rdy=%b data=%h expected 1/23", ready, data);
    end
    checks++;
    if (errRises !== e0) begin
      errors++; $display("[TB] FAIL timeout_no_err: got %0d pulses expected 0", errRises - e0);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("[TB] FAIL timeout_ovf_sticky: got %b expected 1", overflow);
    end
    popOnce();
  endtask

  task automatic test_midframe_reset();
    sendByte(8'h5A);
    sendByte(8'h3C);
    checks++;
    if (ready !== 1'b1 || data !== 8'h5A) begin
      errors++; $display("[TB] FAIL mreset_queued: got rdy=%b data=%h expected 1/5a", ready, data);
    end
    sendBits(makeFrame(8'h66, 1'b0), 0, 5);
    @(negedge clk);
    #2 clrn = 1'b0;
    #3;
    checks++;
    if ({ready, overflow, frame_err, data} !== 11'h000) begin
      errors++;
      $display("[TB] FAIL mreset_async: got rdy=%b ovf=%b err=%b data=%h expected all 0",
               ready, overflow, frame_err, data);
    end
    @(negedge clk); clrn = 1'b1;
    repeat (5) @(negedge clk);
    sendByte(8'h74);
    checks++;
    if (ready !== 1'b1 || data !== 8'h74 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mreset_next_frame: got rdy=%b data=%h ovf=%b expected 1/74/0",
               ready, data, overflow);
    end
    popOnce();
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("[TB] FAIL mreset_single_entry: got rdy=%b expected 0", ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity_error();
    test_overflow();
    test_timeout();
    test_midframe_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
